pong_engine: RTL and testbench

Parametrised two-player Pong game engine with per-player paddles, scoring, serve delay and game-over/restart. It sits between the pixel-clock domain of the VGA timing block and its RGB inputs. It consumes the current pixel coordinates and player buttons, and returns registered RGB. It supersedes the single-player fixed-geometry game logic.

---
 rtl/pong_engine.sv | 212 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Two-player Pong engine: tick-paced game state (serve/play/over, paddles, scores)
// and a one-cycle-latency pixel colour lookup for the VGA timing block.
module pong_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_W      = 20,
  parameter int BALL_H      = 27,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 80,
  parameter int PADDLE_L_X  = 40,
  parameter int PADDLE_R_X  = 592,
  parameter int TIMESTEP    = 100000,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_MAX   = 9
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [1:0] btn_up_i,
  input  logic [1:0] btn_dwn_i,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic [3:0] score_l_o,
  output logic [3:0] score_r_o,
  output logic       game_over_o,
  output logic       tick_o
);
  localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam logic [TW-1:0] TMAX    = TW'(TIMESTEP - 1);
  localparam logic [SW-1:0] SERVE_N = SW'(SERVE_TICKS);
  localparam logic [3:0]    SMAX    = 4'(SCORE_MAX);
  localparam logic [9:0] X0     = 10'((H_ACTIVE - BALL_W) / 2);
  localparam logic [9:0] Y0     = 10'((V_ACTIVE - BALL_H) / 2);
  localparam logic [9:0] P0     = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PMAX   = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] XMAX   = 10'(H_ACTIVE - BALL_W);
  localparam logic [9:0] YMAX   = 10'(V_ACTIVE - BALL_H);
  localparam logic [9:0] XL_HIT = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] BW11 = 11'(BALL_W);
  localparam logic [10:0] BH11 = 11'(BALL_H);
  localparam logic [10:0] PW11 = 11'(PADDLE_W);
  localparam logic [10:0] PH11 = 11'(PADDLE_H);
  localparam logic [10:0] HA11 = 11'(H_ACTIVE);
  localparam logic [10:0] VA11 = 11'(V_ACTIVE);
  localparam logic [10:0] PL11 = 11'(PADDLE_L_X);
  localparam logic [10:0] PR11 = 11'(PADDLE_R_X);
  localparam logic [10:0] HM11 = 11'(H_ACTIVE / 2);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  logic [TW-1:0] tick_cnt_q;
  state_t        state_q, state_d;
  logic [SW-1:0] serve_q, serve_d, serve_inc;
  logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic          x_dir_q, x_dir_d, y_dir_q, y_dir_d, xd, yd;
  logic [9:0]    pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d, score_inc;
  logic          ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic [10:0]   x11, y11, bx11, by11, pl11, pr11;
  logic          in_ball, in_pad;
  logic [11:0]   rgb_q, rgb_d;

  assign tick_o = (tick_cnt_q == TMAX);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     tick_cnt_q <= '0;
    else if (tick_o) tick_cnt_q <= '0;
    else             tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  function automatic logic [9:0] pad_step(input logic [9:0] p, input logic up, input logic dn);
    logic [9:0] r;
    r = p;
    if (up && !dn && p != 10'd0)   r = p - 10'd1;
    else if (dn && !up && p < PMAX) r = p + 10'd1;
    return r;
  endfunction

  assign bx11 = {1'b0, ball_x_q};
  assign by11 = {1'b0, ball_y_q};
  assign pl11 = {1'b0, pad_l_q};
  assign pr11 = {1'b0, pad_r_q};
  assign ovl_l  = (by11 + BH11 > pl11) && (by11 < pl11 + PH11);
  assign ovl_r  = (by11 + BH11 > pr11) && (by11 < pr11 + PH11);
  assign hit_l  = !x_dir_q && (ball_x_q == XL_HIT) && ovl_l;
  assign hit_r  = x_dir_q && (bx11 + BW11 == PR11) && ovl_r;
  assign miss_l = !x_dir_q && (ball_x_q == 10'd0);
  assign miss_r = x_dir_q && (ball_x_q == XMAX);

  always_comb begin
    state_d   = state_q;
    serve_d   = serve_q;
    serve_inc = serve_q + SW'(1);
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    x_dir_d   = x_dir_q;
    y_dir_d   = y_dir_q;
    pad_l_d   = pad_l_q;
    pad_r_d   = pad_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    score_inc = 4'd0;
    xd        = x_dir_q;
    yd        = y_dir_q;
    if (state_q != OVER) begin
      pad_l_d = pad_step(pad_l_q, btn_up_i[0], btn_dwn_i[0]);
      pad_r_d = pad_step(pad_r_q, btn_up_i[1], btn_dwn_i[1]);
    end
    case (state_q)
      SERVE: begin
        if (serve_inc == SERVE_N) begin
          serve_d = '0;
          state_d = PLAY;
        end else begin
          serve_d = serve_inc;
        end
      end
      PLAY: begin
        if (hit_l) xd = 1'b1;
        if (hit_r) xd = 1'b0;
        if (ball_y_q == 10'd0) yd = 1'b1;
        if (ball_y_q == YMAX)  yd = 1'b0;
        if (miss_l || miss_r) begin
          // Recentre and serve toward whoever conceded the point.
          ball_x_d  = X0;
          ball_y_d  = Y0;
          x_dir_d   = miss_r;
          score_inc = miss_l ? score_r_q + 4'd1 : score_l_q + 4'd1;
          if (miss_l) score_r_d = score_inc;
          else        score_l_d = score_inc;
          state_d   = (score_inc == SMAX) ? OVER : SERVE;
        end else begin
          x_dir_d  = xd;
          y_dir_d  = yd;
          ball_x_d = xd ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
          ball_y_d = yd ? ball_y_q + 10'd1 : ball_y_q - 10'd1;
        end
      end
      OVER: begin
        if (btn_up_i == 2'b11) begin
          state_d   = SERVE;
          serve_d   = '0;
          ball_x_d  = X0;
          ball_y_d  = Y0;
          x_dir_d   = 1'b1;
          y_dir_d   = 1'b1;
          pad_l_d   = P0;
          pad_r_d   = P0;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= SERVE;
      serve_q   <= '0;
      ball_x_q  <= X0;
      ball_y_q  <= Y0;
      x_dir_q   <= 1'b1;
      y_dir_q   <= 1'b1;
      pad_l_q   <= P0;
      pad_r_q   <= P0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
    end else if (tick_o) begin
      state_q   <= state_d;
      serve_q   <= serve_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      x_dir_q   <= x_dir_d;
      y_dir_q   <= y_dir_d;
      pad_l_q   <= pad_l_d;
      pad_r_q   <= pad_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign x11 = {1'b0, x_i};
  assign y11 = {1'b0, y_i};
  assign in_ball = (x11 >= bx11) && (x11 < bx11 + BW11) &&
                   (y11 >= by11) && (y11 < by11 + BH11) && (state_q != OVER);
  assign in_pad  = ((x11 >= PL11) && (x11 < PL11 + PW11) && (y11 >= pl11) && (y11 < pl11 + PH11)) ||
                   ((x11 >= PR11) && (x11 < PR11 + PW11) && (y11 >= pr11) && (y11 < pr11 + PH11));

  always_comb begin
    rgb_d = (state_q == OVER) ? 12'hFF0 : 12'hFFF;
    if (x11 >= HA11 || y11 >= VA11) rgb_d = 12'h000;
    else if (in_ball)               rgb_d = 12'h00F;
    else if (in_pad)                rgb_d = 12'h000;
    else if (x11 == HM11)           rgb_d = 12'hF00;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rgb_q <= 12'h000;
    else         rgb_q <= rgb_d;
  end

  assign red_o       = rgb_q[11:8];
  assign green_o     = rgb_q[7:4];
  assign blue_o      = rgb_q[3:0];
  assign score_l_o   = score_l_q;
  assign score_r_o   = score_r_q;
  assign game_over_o = (state_q == OVER);
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine with a 4-cycle tick, 2-tick serve and a 2-point game.
module tb_pong_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_px, y_px;
  logic [1:0] up, dn;
  logic [3:0] red, green, blue, score_l, score_r;
  logic       game_over, tick;
  int checks = 0;
  int fails  = 0;
  int tb_ticks = 0;
  int t0;

  pong_engine #(.TIMESTEP(4), .SERVE_TICKS(2), .SCORE_MAX(2)) dut (
    .clk_i(clk), .reset_i(reset), .x_i(x_px), .y_i(y_px),
    .btn_up_i(up), .btn_dwn_i(dn),
    .red_o(red), .green_o(green), .blue_o(blue),
    .score_l_o(score_l), .score_r_o(score_r),
    .game_over_o(game_over), .tick_o(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    int g;
    g = 0;
    while (tick !== 1'b1 && g < 16) begin
      @(negedge clk);
      g++;
    end
    chk("tick_wait", int'(tick), 1);
    @(posedge clk);
    #1;
    tb_ticks++;
  endtask

  task automatic wait_x(input string tag, input int wx, input int wd);
    int n;
    n = 0;
    while (!(int'(dut.ball_x_q) == wx && int'(dut.x_dir_q) == wd) && n < 1000) begin
      do_tick();
      n++;
    end
    chk(tag, int'(dut.ball_x_q), wx);
  endtask

  task automatic wait_y(input string tag, input int wy);
    int n;
    n = 0;
    while (int'(dut.ball_y_q) != wy && n < 1000) begin
      do_tick();
      n++;
    end
    chk(tag, int'(dut.ball_y_q), wy);
  endtask

  task automatic chk_pix(input string tag, input int px, input int py, input int exp);
    x_px = 10'(px);
    y_px = 10'(py);
    @(posedge clk);
    #1;
    chk(tag, int'({red, green, blue}), exp);
  endtask

  task automatic chk_ball(input string tag, input int bx, input int by, input int xdir, input int ydir);
    chk({tag, "_x"}, int'(dut.ball_x_q), bx);
    chk({tag, "_y"}, int'(dut.ball_y_q), by);
    chk({tag, "_xdir"}, int'(dut.x_dir_q), xdir);
    chk({tag, "_ydir"}, int'(dut.y_dir_q), ydir);
  endtask

  initial begin
    reset = 1'b1; x_px = 10'd0; y_px = 10'd0; up = 2'b00; dn = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    chk("rst_over", int'(game_over), 0);
    chk_ball("rst_ball", 310, 226, 1, 1);
    chk("rst_pad_l", int'(dut.pad_l_q), 200);
    chk("rst_pad_r", int'(dut.pad_r_q), 200);
    chk("rst_state", int'(dut.state_q), 0);
    x_px = 10'd100; y_px = 10'd100;
    @(negedge clk);
    reset = 1'b0;
    // tick_o must be high after edges 3 and 7 only; ball held through 2 serve ticks
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("tick_period", int'(tick), (i % 4 == 3) ? 1 : 0);
      if (i == 4 || i == 8) chk_ball("serve_hold", 310, 226, 1, 1);
    end
    chk("enter_play", int'(dut.state_q), 1);
    tb_ticks = 2;
    do_tick();
    chk_ball("first_move", 311, 227, 1, 1);

    up = 2'b01; dn = 2'b01;
    do_tick();
    chk("both_btn_pad_l", int'(dut.pad_l_q), 200);
    chk("both_btn_pad_r", int'(dut.pad_r_q), 200);

    up = 2'b01; dn = 2'b10;
    repeat (200) do_tick();
    chk("pad_l_top", int'(dut.pad_l_q), 0);
    chk("pad_r_bottom", int'(dut.pad_r_q), 400);
    do_tick();
    chk("pad_l_clamp0", int'(dut.pad_l_q), 0);
    chk("pad_r_clamp400", int'(dut.pad_r_q), 400);

    up = 2'b00; dn = 2'b01;
    t0 = tb_ticks;
    wait_y("reach_y453", 453);
    chk("y453_dir_before", int'(dut.y_dir_q), 1);
    do_tick();
    chk("y_wall_y", int'(dut.ball_y_q), 452);
    chk("y_wall_dir", int'(dut.y_dir_q), 0);
    wait_x("reach_x572", 572, 1);
    chk("x572_y", int'(dut.ball_y_q), 418);
    do_tick();
    chk_ball("right_hit", 571, 417, 0, 0);
    while (tb_ticks - t0 < 200) do_tick();
    chk("pad_l_back", int'(dut.pad_l_q), 200);
    dn = 2'b00;

    wait_x("reach_x0", 0, 0);
    chk("x0_y", int'(dut.ball_y_q), 154);
    do_tick();
    chk("miss_l_score_r", int'(score_r), 1);
    chk("miss_l_score_l", int'(score_l), 0);
    chk_ball("miss_l_ball", 310, 226, 0, 1);
    chk("miss_l_state", int'(dut.state_q), 0);

    dn = 2'b01;
    repeat (200) do_tick();
    chk("pad_l_400", int'(dut.pad_l_q), 400);
    dn = 2'b00;
    wait_x("reach_x48", 48, 0);
    chk("x48_y", int'(dut.ball_y_q), 418);
    do_tick();
    chk_ball("left_hit", 49, 417, 1, 0);
    chk("left_hit_score_r", int'(score_r), 1);
    chk("left_hit_score_l", int'(score_l), 0);

    wait_x("reach_x620a", 620, 1);
    chk("x620a_y", int'(dut.ball_y_q), 154);
    do_tick();
    chk("miss_r1_score_l", int'(score_l), 1);
    chk_ball("miss_r1_ball", 310, 226, 1, 1);
    chk("miss_r1_over", int'(game_over), 0);

    up = 2'b10;
    repeat (100) do_tick();
    chk("pad_r_300", int'(dut.pad_r_q), 300);
    up = 2'b00;
    wait_x("reach_x620b", 620, 1);
    chk("x620b_y", int'(dut.ball_y_q), 370);
    do_tick();
    chk("over_score_l", int'(score_l), 2);
    chk("over_flag", int'(game_over), 1);
    chk("over_state", int'(dut.state_q), 2);

    chk_pix("over_ball_hidden", 310, 226, 'hFF0);
    chk_pix("over_pad_l", 44, 450, 'h000);
    chk_pix("over_offscreen", 700, 10, 'h000);
    chk_pix("over_midline", 320, 100, 'hF00);
    up = 2'b01;
    do_tick();
    chk("over_pad_frozen", int'(dut.pad_l_q), 400);
    chk("over_still", int'(game_over), 1);
    up = 2'b11;
    do_tick();
    up = 2'b00;
    chk("restart_score_l", int'(score_l), 0);
    chk("restart_score_r", int'(score_r), 0);
    chk("restart_over", int'(game_over), 0);
    chk("restart_pad_l", int'(dut.pad_l_q), 200);
    chk("restart_pad_r", int'(dut.pad_r_q), 200);
    chk_ball("restart_ball", 310, 226, 1, 1);
    chk_pix("ball_first_px", 310, 226, 'h00F);
    chk_pix("ball_last_px", 329, 252, 'h00F);
    chk_pix("past_ball", 330, 252, 'hFFF);
    chk_pix("midline", 320, 100, 'hF00);
    chk_pix("pad_r_px", 592, 200, 'h000);
    chk_pix("corner_bg", 639, 479, 'hFFF);
    chk_pix("x_off", 640, 0, 'h000);

    up = 2'b01;
    repeat (5) do_tick();
    chk("pre_reset_pad_l", int'(dut.pad_l_q), 195);
    reset = 1'b1;
    #1;
    chk("mid_rst_pad_l", int'(dut.pad_l_q), 200);
    chk_ball("mid_rst_ball", 310, 226, 1, 1);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_rgb", int'({red, green, blue}), 0);
    up = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_tick", int'(tick), (i == 3) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
